imem_loader_arb: RTL and testbench

IMEM_LOADER_ARB -- requirements
Module: imem_loader_arb

---
 rtl/imem_loader_arb.sv | 141 ++++++++++++++
 tb/tb_imem_loader_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_arb.sv
// Arbitrates the instruction-memory port between a byte-stream image loader, the IF stage and a debug reader.
// Loader bytes are packed little-endian into words; debug reads steal one cycle from the CPU.
module imem_loader_arb #(
  parameter int AW = 6
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [31:0]   pc,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  output logic          ld_ready,
  input  logic          ld_done,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_ack,
  output logic [31:0]   dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   ins,
  output logic          cpu_stall,
  output logic          load_err
);

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DBG} state_t;

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_MAX = '1;

  state_t        state_q, state_d;
  logic [AW-1:0] word_ptr_q, word_ptr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   asm_q, asm_d;
  logic          wr_pend_q, wr_pend_d;
  logic          done_pend_q, done_pend_d;
  logic          wrapped_q, wrapped_d;
  logic          load_err_q, load_err_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic [31:0]   dbg_rdata_q, dbg_rdata_d;

  logic unused_pc;
  assign unused_pc = ^{pc[31:AW+2], pc[1:0]};

  always_comb begin
    state_d     = state_q;
    word_ptr_d  = word_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    wr_pend_d   = wr_pend_q;
    done_pend_d = done_pend_q;
    wrapped_d   = wrapped_q;
    load_err_d  = load_err_q;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = dbg_rdata_q;
    ld_ready    = 1'b0;
    cpu_stall   = 1'b1;
    ins         = 32'h0;
    mem_we      = 1'b0;
    mem_addr    = word_ptr_q;
    mem_wdata   = asm_q;

    case (state_q)
      ST_LOAD: begin
        if (wr_pend_q) begin
          // Write cycle: the assembly register is cleared so a later partial word pads with zeros.
          mem_we     = 1'b1;
          word_ptr_d = word_ptr_q + PTR_ONE;
          byte_cnt_d = 2'd0;
          asm_d      = 32'h0;
          wr_pend_d  = 1'b0;
          if (word_ptr_q == PTR_MAX) wrapped_d = 1'b1;
          if (wrapped_q) load_err_d = 1'b1;
          if (done_pend_q || ld_done) begin
            done_pend_d = 1'b0;
            state_d     = ST_RUN;
          end
        end else begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            asm_d[{byte_cnt_q, 3'b000} +: 8] = ld_byte;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) wr_pend_d = 1'b1;
          end
          if (ld_done) begin
            if (ld_valid || byte_cnt_q != 2'd0) begin
              wr_pend_d   = 1'b1;
              done_pend_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
      end
      ST_RUN: begin
        cpu_stall = 1'b0;
        mem_addr  = pc[AW+1:2];
        ins       = mem_rdata;
        if (dbg_req) state_d = ST_DBG;
      end
      ST_DBG: begin
        mem_addr    = dbg_addr;
        dbg_rdata_d = mem_rdata;
        dbg_ack_d   = 1'b1;
        state_d     = ST_RUN;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_LOAD;
      word_ptr_q  <= '0;
      byte_cnt_q  <= 2'd0;
      asm_q       <= 32'h0;
      wr_pend_q   <= 1'b0;
      done_pend_q <= 1'b0;
      wrapped_q   <= 1'b0;
      load_err_q  <= 1'b0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      word_ptr_q  <= word_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      wr_pend_q   <= wr_pend_d;
      done_pend_q <= done_pend_d;
      wrapped_q   <= wrapped_d;
      load_err_q  <= load_err_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader_arb.sv
// Directed/randomized bench for imem_loader_arb with a word-list model of the loaded image.
// Checks reset values, loader packing/writes, RUN fetch, debug reads and overflow flag.
// Loader stimulus is randomly throttled; no backpressure on the memory model.
`define CHK(tag, obs, exp) \
    begin checks++; assert ((obs) === (exp)) else begin errors++; \
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, (obs), (exp)); end end

module tb_imem_loader_arb;
    localparam int AW = 6;

    logic          clock, resetn;
    logic [31:0]   pc;
    logic          ld_valid, ld_ready, ld_done;
    logic [7:0]    ld_byte;
    logic          dbg_req, dbg_ack;
    logic [AW-1:0] dbg_addr, mem_addr;
    logic [31:0]   dbg_rdata, mem_wdata, mem_rdata, ins;
    logic          mem_we, cpu_stall, load_err;

    int checks = 0;
    int errors = 0;
    int rdy_viol = 0;

    logic [31:0] dut_mem [64];
    logic [31:0] ref_mem [64];
    logic [7:0]  img [$];
    logic [37:0] wr_q [$];
    bit          coincide;

    imem_loader_arb #(.AW(AW)) dut (
        .clock(clock), .resetn(resetn), .pc(pc),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready), .ld_done(ld_done),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ins(ins), .cpu_stall(cpu_stall), .load_err(load_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory on the inverted clock: combinational read, write on the falling edge.
    assign mem_rdata = dut_mem[mem_addr];
    always @(negedge clock) begin
        if (resetn && mem_we) begin
            dut_mem[mem_addr] <= mem_wdata;
            wr_q.push_back({mem_addr, mem_wdata});
            if (ld_ready !== 1'b0) rdy_viol++;
        end
    end

    task automatic check_reset_outs();
        `CHK("rst_ld_ready", ld_ready, 1'b1)
        `CHK("rst_cpu_stall", cpu_stall, 1'b1)
        `CHK("rst_ins", ins, 32'h0)
        `CHK("rst_mem_we", mem_we, 1'b0)
        `CHK("rst_dbg_ack", dbg_ack, 1'b0)
        `CHK("rst_dbg_rdata", dbg_rdata, 32'h0)
        `CHK("rst_load_err", load_err, 1'b0)
        `CHK("rst_mem_addr", mem_addr, 6'd0)
        checks++;
        if (mem_addr !== 6'd0 || mem_we !== 1'b0 || ld_ready !== 1'b1 || cpu_stall !== 1'b1) begin
            errors++;
            $error("FAIL reset_state: mem_addr=0x%0h mem_we=%b ld_ready=%b cpu_stall=%b",
                   mem_addr, mem_we, ld_ready, cpu_stall);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0; ld_valid = 1'b0; ld_done = 1'b0; dbg_req = 1'b0;
        #1 check_reset_outs();
        @(negedge clock);
        wr_q.delete();
        resetn = 1'b1;
    endtask

    task automatic check_writes();
        int nw;
        logic [31:0] word;
        nw = (img.size() + 3) / 4;
        `CHK("write_count", wr_q.size(), nw)
        for (int w = 0; w < nw; w++) begin
            word = 32'h0;
            for (int b = 0; b < 4; b++)
                if (4*w + b < img.size()) word[8*b +: 8] = img[4*w + b];
            ref_mem[w % 64] = word;
            if (w < wr_q.size()) begin
                `CHK("write_addr", wr_q[w][37:32], 6'(w % 64))
                `CHK("write_data", wr_q[w][31:0], word)
            end
        end
        `CHK("load_err", load_err, (nw > 64))
        `CHK("ready_in_write", rdy_viol, 0)
    endtask

    task automatic load_image();
        int idx = 0;
        int cyc = 0;
        bit done_sent = 0;
        while (idx < img.size() && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            ld_done  = 1'b0;
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_byte  = img[idx];
            if (ld_valid && ld_ready) begin
                if (coincide && idx == img.size() - 1) begin
                    ld_done = 1'b1;
                    done_sent = 1;
                end
                idx++;
            end
        end
        `CHK("load_progress", idx, img.size())
        @(negedge clock);
        ld_valid = 1'b0;
        ld_done  = !done_sent;
        @(negedge clock);
        ld_done = 1'b0;
        cyc = 0;
        while (cpu_stall !== 1'b0 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (cyc >= 20) begin
            errors++;
            $error("FAIL run_wait_timeout: cpu_stall still 0x%0h after %0d cycles", cpu_stall, cyc);
        end
        `CHK("run_entry", cpu_stall, 1'b0)
        `CHK("run_ld_ready", ld_ready, 1'b0)
        check_writes();
    endtask

    task automatic run_read(input logic [31:0] p);
        @(negedge clock);
        pc = p;
        ld_valid = $urandom_range(0, 1);
        #1;
        `CHK("run_mem_addr", mem_addr, p[7:2])
        `CHK("run_ins", ins, ref_mem[p[7:2]])
        `CHK("run_no_we", mem_we, 1'b0)
        ld_valid = 1'b0;
    endtask

    task automatic dbg_read(input logic [5:0] a, input bit b2b);
        @(negedge clock);
        dbg_addr = a; dbg_req = 1'b1;
        @(negedge clock);
        `CHK("dbg_stall", cpu_stall, 1'b1)
        `CHK("dbg_ins", ins, 32'h0)
        `CHK("dbg_mem_addr", mem_addr, a)
        `CHK("dbg_no_early_ack", dbg_ack, 1'b0)
        @(negedge clock);
        `CHK("dbg_ack", dbg_ack, 1'b1)
        `CHK("dbg_rdata", dbg_rdata, ref_mem[a])
        `CHK("dbg_ack_run", cpu_stall, 1'b0)
        if (b2b) begin
            @(negedge clock);
            `CHK("b2b_stall", cpu_stall, 1'b1)
            `CHK("b2b_ack_low", dbg_ack, 1'b0)
            dbg_req = 1'b0;
            @(negedge clock);
            `CHK("b2b_ack", dbg_ack, 1'b1)
        end else begin
            dbg_req = 1'b0;
        end
        @(negedge clock);
        `CHK("ack_one_cycle", dbg_ack, 1'b0)
    endtask

    task automatic set_img4(input logic [31:0] w);
        for (int b = 0; b < 4; b++) img.push_back(w[8*b +: 8]);
    endtask

    initial begin
        resetn = 1'b0; pc = 32'h0; ld_valid = 1'b0; ld_byte = 8'h0; ld_done = 1'b0;
        dbg_req = 1'b0; dbg_addr = '0;
        for (int i = 0; i < 64; i++) begin dut_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        #12 check_reset_outs();
        @(negedge clock);
        resetn = 1'b1;

        img.delete(); set_img4(32'h24020013); coincide = 0;
        load_image();
        `CHK("basic_word", wr_q[0][31:0], 32'h24020013)
        run_read(32'h0000_0000);
        run_read(32'h0000_0004);
        run_read(32'h0000_0104);
        for (int i = 0; i < 4; i++) run_read($urandom);

        do_reset();
        img.delete(); set_img4(32'h24020013); set_img4($urandom); set_img4(32'h8C010000);
        coincide = 1;
        load_image();
        dbg_read(6'd2, 0);
        `CHK("dbg_word2", dbg_rdata, 32'h8C010000)
        dbg_read(6'($urandom_range(0, 63)), 1);

        do_reset();
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        coincide = $urandom_range(0, 1);
        load_image();
        `CHK("five_w0", wr_q[0][31:0], 32'hDDCCBBAA)
        `CHK("five_w1", wr_q[1][31:0], 32'h000000EE)

        do_reset();
        @(negedge clock); ld_valid = 1'b1; ld_byte = 8'h11;
        @(negedge clock); ld_byte = 8'h22;
        @(negedge clock); ld_valid = 1'b0; resetn = 1'b0;
        #1 check_reset_outs();
        @(negedge clock); wr_q.delete(); resetn = 1'b1;
        img = '{8'h01, 8'h02, 8'h03, 8'h04}; coincide = 0;
        load_image();
        `CHK("reload_word", wr_q[0][31:0], 32'h04030201)

        do_reset();
        img.delete();
        for (int i = 0; i < 260; i++) img.push_back(8'($urandom));
        coincide = $urandom_range(0, 1);
        load_image();
        run_read($urandom);
        `CHK("load_err_sticky", load_err, 1'b1)

        for (int it = 0; it < 4; it++) begin
            do_reset();
            img.delete();
            for (int i = 0; i < $urandom_range(0, 40); i++) img.push_back(8'($urandom));
            coincide = $urandom_range(0, 1);
            load_image();
            for (int r = 0; r < 3; r++) run_read($urandom);
            dbg_read(6'($urandom_range(0, 63)), $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
